// File: rtl/leg_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 control sequencer.
// Opcode constants are left-aligned slices of the instruction word.
package leg_ctrl_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      MEM   = 2'd2,
      HALT  = 2'd3
   } state_e;

   localparam logic [10:0] OP_ADD   = 11'h458;
   localparam logic [10:0] OP_SUB   = 11'h658;
   localparam logic [10:0] OP_AND   = 11'h450;
   localparam logic [10:0] OP_ORR   = 11'h550;
   localparam logic [10:0] OP_ADDS  = 11'h558;
   localparam logic [10:0] OP_SUBS  = 11'h758;
   localparam logic [10:0] OP_STUR  = 11'h7C0;
   localparam logic [10:0] OP_LDUR  = 11'h7C2;
   localparam logic [10:0] OP_BR    = 11'h6B0;
   localparam logic [9:0]  OP_ADDI  = 10'h244;
   localparam logic [9:0]  OP_SUBI  = 10'h344;
   localparam logic [7:0]  OP_BCOND = 8'h54;
   localparam logic [7:0]  OP_CBZ   = 8'hB4;
   localparam logic [7:0]  OP_CBNZ  = 8'hB5;
   localparam logic [5:0]  OP_B     = 6'h05;
   localparam logic [5:0]  OP_BL    = 6'h25;

   localparam logic [4:0] ALU_AND   = 5'b00000;
   localparam logic [4:0] ALU_ORR   = 5'b00100;
   localparam logic [4:0] ALU_ADD   = 5'b01000;
   localparam logic [4:0] ALU_SUB   = 5'b01001;
   localparam logic [4:0] ALU_PASSB = 5'b10100;

   localparam logic [1:0] PC_HOLD = 2'd0;
   localparam logic [1:0] PC_INC  = 2'd1;
   localparam logic [1:0] PC_LOAD = 2'd2;
   localparam logic [1:0] PC_REL  = 2'd3;

   localparam logic [1:0] DS_ALU  = 2'd0;
   localparam logic [1:0] DS_REGB = 2'd1;
   localparam logic [1:0] DS_PC4  = 2'd2;
   localparam logic [1:0] DS_MEM  = 2'd3;

   typedef struct packed {
      logic       set_flags;
      logic [1:0] pc_sel;
      logic       pc_src;
      logic [1:0] data_src;
      logic       alu_src;
      logic [4:0] alu_sel;
      logic       alu_carry_in;
      logic       mem_write;
      logic       reg_write;
      logic [4:0] reg_addr_in;
      logic [4:0] reg_addr_a;
      logic [4:0] reg_addr_b;
   } ctrl_word_t;

   function automatic logic cond_met(
      input logic [3:0] cond,
      input logic [3:0] f
   );
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      // odd codes invert the even test, except 14/15 which are both always
      return (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
   endfunction

endpackage

// File: rtl/leg_imm_gen.sv
// Combinational immediate extraction for the LEGv8 control unit.
// Branch offsets are word offsets, scaled to bytes here.
module leg_imm_gen
   import leg_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic [63:0] k
);

   logic [10:0] op11;
   logic [9:0]  op10;
   logic [7:0]  op8;
   logic [5:0]  op6;

   assign op11 = ir[31:21];
   assign op10 = ir[31:22];
   assign op8  = ir[31:24];
   assign op6  = ir[31:26];

   always_comb begin
      k = '0;
      unique case (1'b1)
         op10 == OP_ADDI,
         op10 == OP_SUBI:
            k = {52'd0, ir[21:10]};
         op11 == OP_STUR,
         op11 == OP_LDUR:
            k = {{55{ir[20]}}, ir[20:12]};
         op6 == OP_B,
         op6 == OP_BL:
            k = {{36{ir[25]}}, ir[25:0], 2'b00};
         op8 == OP_BCOND,
         op8 == OP_CBZ,
         op8 == OP_CBNZ:
            k = {{43{ir[23]}}, ir[23:5], 2'b00};
         default:
            k = '0;
      endcase
   end

endmodule

// File: rtl/leg_control_unit.sv
// FETCH/EXEC/MEM sequencer driving the LEGv8 datapath control word.
// Define LEG_CTRL_PERF_EN to add InstrCount/StallCount outputs.
module leg_control_unit
   import leg_ctrl_pkg::*;
#(
   parameter int unsigned LINK_REG        = 30,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] Instruction,
   input  logic [3:0]  Flags,
   input  logic [3:0]  Status,
   input  logic        Stall,
   output logic [29:0] CtrlWord,
   output logic [63:0] K,
   output logic        Halted,
   output logic [1:0]  StateOut
`ifdef LEG_CTRL_PERF_EN
   ,
   output logic [31:0] InstrCount,
   output logic [31:0] StallCount
`endif
);

   state_e      state;
   state_e      ex_next;
   logic [31:0] ir;
   logic [63:0] imm;
   ctrl_word_t  dec;
   ctrl_word_t  mem_cw;
   ctrl_word_t  cw;

   logic [10:0] op11;
   logic [9:0]  op10;
   logic [7:0]  op8;
   logic [5:0]  op6;
   logic [4:0]  rd, rn, rm;
   logic        is_r, is_ri, is_stur, is_ldur;
   logic        is_b, is_bc, is_cb, is_br, bad;
   logic        frozen;
   logic        unused_status;

   assign op11 = ir[31:21];
   assign op10 = ir[31:22];
   assign op8  = ir[31:24];
   assign op6  = ir[31:26];
   assign rd   = ir[4:0];
   assign rn   = ir[9:5];
   assign rm   = ir[20:16];

   assign is_r = op11 inside {OP_ADD, OP_SUB, OP_AND,
                              OP_ORR, OP_ADDS, OP_SUBS};
   assign is_ri   = op10 inside {OP_ADDI, OP_SUBI};
   assign is_stur = (op11 == OP_STUR);
   assign is_ldur = (op11 == OP_LDUR);
   assign is_br   = (op11 == OP_BR);
   assign is_b    = op6 inside {OP_B, OP_BL};
   assign is_bc   = (op8 == OP_BCOND);
   assign is_cb   = op8 inside {OP_CBZ, OP_CBNZ};
   assign bad     = ~(is_r | is_ri | is_stur | is_ldur |
                      is_b | is_bc | is_cb | is_br);

   // CBZ/CBNZ only look at the live zero bit
   assign unused_status = ^{Status[3], Status[1:0]};

   leg_imm_gen u_imm (
      .ir (ir),
      .k  (imm)
   );

   always_comb begin
      dec = '0;
      unique case (1'b1)
         is_r, is_ri: begin
            dec.reg_addr_a  = rn;
            dec.reg_addr_b  = rm;
            dec.reg_addr_in = rd;
            dec.reg_write   = 1'b1;
            dec.pc_sel      = PC_INC;
            dec.alu_src     = is_ri;
            dec.set_flags   = (op11 == OP_ADDS) ||
                              (op11 == OP_SUBS);
            if (is_ri)
               dec.alu_sel = (op10 == OP_SUBI) ? ALU_SUB
                                               : ALU_ADD;
            else
               case (op11)
                  OP_SUB, OP_SUBS: dec.alu_sel = ALU_SUB;
                  OP_AND:          dec.alu_sel = ALU_AND;
                  OP_ORR:          dec.alu_sel = ALU_ORR;
                  default:         dec.alu_sel = ALU_ADD;
               endcase
         end
         is_stur: begin
            dec.alu_src    = 1'b1;
            dec.alu_sel    = ALU_ADD;
            dec.reg_addr_a = rn;
            dec.reg_addr_b = rd;
            dec.data_src   = DS_REGB;
            dec.mem_write  = 1'b1;
            dec.pc_sel     = PC_INC;
         end
         is_ldur: begin
            dec.alu_src    = 1'b1;
            dec.alu_sel    = ALU_ADD;
            dec.reg_addr_a = rn;
            dec.pc_sel     = PC_HOLD;
         end
         is_b: begin
            dec.pc_src = 1'b1;
            dec.pc_sel = PC_REL;
            if (op6 == OP_BL) begin
               dec.data_src    = DS_PC4;
               dec.reg_write   = 1'b1;
               dec.reg_addr_in = LINK_REG[4:0];
            end
         end
         is_bc: begin
            dec.pc_src = 1'b1;
            dec.pc_sel = cond_met(ir[3:0], Flags) ? PC_REL
                                                  : PC_INC;
         end
         is_cb: begin
            dec.pc_src     = 1'b1;
            dec.alu_sel    = ALU_PASSB;
            dec.reg_addr_b = rd;
            dec.pc_sel = ((op8 == OP_CBZ) == Status[2]) ? PC_REL
                                                        : PC_INC;
         end
         is_br: begin
            dec.reg_addr_a = rn;
            dec.pc_src     = 1'b0;
            dec.pc_sel     = PC_LOAD;
         end
         default:
            dec.pc_sel = HALT_ON_ILLEGAL ? PC_HOLD : PC_INC;
      endcase
   end

   always_comb begin
      mem_cw             = '0;
      mem_cw.alu_src     = 1'b1;
      mem_cw.alu_sel     = ALU_ADD;
      mem_cw.reg_addr_a  = rn;
      mem_cw.data_src    = DS_MEM;
      mem_cw.reg_write   = 1'b1;
      mem_cw.reg_addr_in = rd;
      mem_cw.pc_sel      = PC_INC;
   end

   always_comb begin
      ex_next = FETCH;
      if (bad && HALT_ON_ILLEGAL)
         ex_next = HALT;
      else if (is_ldur)
         ex_next = MEM;
   end

   assign frozen = Stall && (state != HALT);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= FETCH;
         ir    <= '0;
      end else if (!frozen) begin
         case (state)
            FETCH: begin
               ir    <= Instruction;
               state <= EXEC;
            end
            EXEC:    state <= ex_next;
            MEM:     state <= FETCH;
            default: state <= HALT;
         endcase
      end
   end

   always_comb begin
      cw = '0;
      if (!Rst && !frozen) begin
         case (state)
            EXEC:    cw = dec;
            MEM:     cw = mem_cw;
            default: cw = '0;
         endcase
      end
   end

   assign CtrlWord = cw;
   assign K        = Rst ? 64'd0 : imm;
   assign Halted   = (state == HALT);
   assign StateOut = state;

`ifdef LEG_CTRL_PERF_EN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         InstrCount <= '0;
         StallCount <= '0;
      end else begin
         if (frozen)
            StallCount <= StallCount + 32'd1;
         if (!frozen && (state == MEM ||
             (state == EXEC && ex_next == FETCH)))
            InstrCount <= InstrCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_leg_control_unit.sv
// Directed and random checks of leg_control_unit against a
// cycle-level instruction model.
module tb_leg_control_unit;
   import leg_ctrl_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] Instruction;
   logic [3:0]  Flags;
   logic [3:0]  Status;
   logic        Stall;
   logic [29:0] CtrlWord;
   logic [63:0] K;
   logic        Halted;
   logic [1:0]  StateOut;
`ifdef LEG_CTRL_PERF_EN
   logic [31:0] InstrCount;
   logic [31:0] StallCount;
`endif

   int n_chk = 0;
   int n_fail = 0;

   typedef enum int {
      M_ADD, M_SUB, M_AND, M_ORR, M_ADDS, M_SUBS,
      M_ADDI, M_SUBI, M_STUR, M_LDUR, M_B, M_BL,
      M_BCOND, M_CBZ, M_CBNZ, M_BR, M_ILL
   } mn_e;

   // model: 0 fetch, 1 exec, 2 mem, 3 halt
   int          m_st;
   logic [31:0] m_ir;
   int unsigned m_ic;
   int unsigned m_sc;

   leg_control_unit dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Instruction (Instruction),
      .Flags       (Flags),
      .Status      (Status),
      .Stall       (Stall),
      .CtrlWord    (CtrlWord),
      .K           (K),
      .Halted      (Halted),
      .StateOut    (StateOut)
`ifdef LEG_CTRL_PERF_EN
      ,
      .InstrCount  (InstrCount),
      .StallCount  (StallCount)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic mn_e classify(input logic [31:0] w);
      case (w[31:21])
         11'h458: return M_ADD;
         11'h658: return M_SUB;
         11'h450: return M_AND;
         11'h550: return M_ORR;
         11'h558: return M_ADDS;
         11'h758: return M_SUBS;
         11'h7C0: return M_STUR;
         11'h7C2: return M_LDUR;
         11'h6B0: return M_BR;
         default: ;
      endcase
      if (w[31:22] == 10'h244) return M_ADDI;
      if (w[31:22] == 10'h344) return M_SUBI;
      if (w[31:24] == 8'h54)   return M_BCOND;
      if (w[31:24] == 8'hB4)   return M_CBZ;
      if (w[31:24] == 8'hB5)   return M_CBNZ;
      if (w[31:26] == 6'h05)   return M_B;
      if (w[31:26] == 6'h25)   return M_BL;
      return M_ILL;
   endfunction

   function automatic logic [31:0] gen(input mn_e m);
      logic [31:0] r;
      r = $urandom();
      case (m)
         M_ADD:   return {11'h458, r[20:0]};
         M_SUB:   return {11'h658, r[20:0]};
         M_AND:   return {11'h450, r[20:0]};
         M_ORR:   return {11'h550, r[20:0]};
         M_ADDS:  return {11'h558, r[20:0]};
         M_SUBS:  return {11'h758, r[20:0]};
         M_STUR:  return {11'h7C0, r[20:0]};
         M_LDUR:  return {11'h7C2, r[20:0]};
         M_BR:    return {11'h6B0, r[20:0]};
         M_ADDI:  return {10'h244, r[21:0]};
         M_SUBI:  return {10'h344, r[21:0]};
         M_BCOND: return {8'h54, r[23:0]};
         M_CBZ:   return {8'hB4, r[23:0]};
         M_CBNZ:  return {8'hB5, r[23:0]};
         M_B:     return {6'h05, r[25:0]};
         M_BL:    return {6'h25, r[25:0]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [29:0] mk(
      input logic sf, input logic [1:0] ps, input logic src,
      input logic [1:0] ds, input logic as, input logic [4:0] alu,
      input logic mw, input logic rw, input logic [4:0] rin,
      input logic [4:0] ra, input logic [4:0] rb);
      return {sf, ps, src, ds, as, alu, 1'b0, mw, rw, rin, ra, rb};
   endfunction

   function automatic logic cond_ok(input logic [3:0] c,
                                    input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return cy;
         4'd3:    return !cy;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return cy && !z;
         4'd9:    return !cy || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [29:0] exp_exec(input logic [31:0] w,
      input logic [3:0] fl, input logic [3:0] st);
      logic [4:0] rd, rn, rm;
      logic [1:0] tk;
      rd = w[4:0]; rn = w[9:5]; rm = w[20:16];
      tk = cond_ok(w[3:0], fl) ? 2'd3 : 2'd1;
      case (classify(w))
         M_ADD:  return mk(0, 2'd1, 0, 2'd0, 0, ALU_ADD, 0, 1, rd, rn, rm);
         M_ADDS: return mk(1, 2'd1, 0, 2'd0, 0, ALU_ADD, 0, 1, rd, rn, rm);
         M_SUB:  return mk(0, 2'd1, 0, 2'd0, 0, ALU_SUB, 0, 1, rd, rn, rm);
         M_SUBS: return mk(1, 2'd1, 0, 2'd0, 0, ALU_SUB, 0, 1, rd, rn, rm);
         M_AND:  return mk(0, 2'd1, 0, 2'd0, 0, ALU_AND, 0, 1, rd, rn, rm);
         M_ORR:  return mk(0, 2'd1, 0, 2'd0, 0, ALU_ORR, 0, 1, rd, rn, rm);
         M_ADDI: return mk(0, 2'd1, 0, 2'd0, 1, ALU_ADD, 0, 1, rd, rn, rm);
         M_SUBI: return mk(0, 2'd1, 0, 2'd0, 1, ALU_SUB, 0, 1, rd, rn, rm);
         M_STUR: return mk(0, 2'd1, 0, 2'd1, 1, ALU_ADD, 1, 0, 5'd0, rn, rd);
         M_LDUR: return mk(0, 2'd0, 0, 2'd0, 1, ALU_ADD, 0, 0, 5'd0, rn, 5'd0);
         M_B:    return mk(0, 2'd3, 1, 2'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0);
         M_BL:   return mk(0, 2'd3, 1, 2'd2, 0, 5'd0, 0, 1, 5'd30, 5'd0, 5'd0);
         M_BCOND: return mk(0, tk, 1, 2'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0);
         M_CBZ:  return mk(0, st[2] ? 2'd3 : 2'd1, 1, 2'd0, 0, ALU_PASSB,
                           0, 0, 5'd0, 5'd0, rd);
         M_CBNZ: return mk(0, st[2] ? 2'd1 : 2'd3, 1, 2'd0, 0, ALU_PASSB,
                           0, 0, 5'd0, 5'd0, rd);
         M_BR:   return mk(0, 2'd2, 0, 2'd0, 0, 5'd0, 0, 0, 5'd0, rn, 5'd0);
         default: return 30'd0;
      endcase
   endfunction

   function automatic logic [63:0] exp_k(input logic [31:0] w);
      case (classify(w))
         M_ADDI, M_SUBI: return 64'(w[21:10]);
         M_STUR, M_LDUR: return 64'($signed(w[20:12]));
         M_B, M_BL:      return 64'($signed(w[25:0])) * 64'd4;
         M_BCOND, M_CBZ, M_CBNZ:
                         return 64'($signed(w[23:5])) * 64'd4;
         default:        return 64'd0;
      endcase
   endfunction

   task automatic drive_check(input logic stall);
      logic [29:0] ecw;
      Stall = stall;
      #1;
      if (Rst || stall || m_st == 0 || m_st == 3)
         ecw = '0;
      else if (m_st == 1)
         ecw = exp_exec(m_ir, Flags, Status);
      else
         ecw = mk(0, 2'd1, 0, 2'd3, 1, ALU_ADD, 0, 1,
                  m_ir[4:0], m_ir[9:5], 5'd0);
      check("ctrl", 64'(CtrlWord), 64'(ecw));
      check("state", 64'(StateOut), 64'(m_st));
      check("halted", 64'(Halted), 64'(m_st == 3));
      if (Rst)
         check("k_rst", K, 64'd0);
      else if (m_st == 1 || m_st == 2)
         check("k", K, exp_k(m_ir));
`ifdef LEG_CTRL_PERF_EN
      check("icnt", 64'(InstrCount), 64'(m_ic));
      check("scnt", 64'(StallCount), 64'(m_sc));
`endif
   endtask

   task automatic tick();
      mn_e m;
      if (Rst) begin
         m_st = 0; m_ir = '0; m_ic = 0; m_sc = 0;
      end else if (m_st == 3) begin
         m_st = 3;
      end else if (Stall) begin
         m_sc++;
      end else if (m_st == 0) begin
         m_ir = Instruction;
         m_st = 1;
      end else if (m_st == 1) begin
         m = classify(m_ir);
         if (m == M_ILL) m_st = 3;
         else if (m == M_LDUR) m_st = 2;
         else begin m_st = 0; m_ic++; end
      end else begin
         m_st = 0;
         m_ic++;
      end
      @(negedge Clk);
   endtask

   task automatic step(input logic stall);
      drive_check(stall);
      tick();
   endtask

   task automatic fetch(input logic [31:0] w);
      Instruction = w;
      step(1'b0);
      Instruction = $urandom();
   endtask

   initial begin
      Rst = 1'b1; Stall = 1'b0; Instruction = '0;
      Flags = '0; Status = '0;
      m_st = 0; m_ir = '0; m_ic = 0; m_sc = 0;
      @(negedge Clk);
      step(1'b0);
      step(1'b0);
      Rst = 1'b0;

      Instruction = 32'h91001441;
      drive_check(1'b0);
      check("addi_fetch_cw", 64'(CtrlWord), 64'd0);
      tick();
      Instruction = $urandom();
      drive_check(1'b0);
      check("addi_alusrc", 64'(CtrlWord[23]), 64'd1);
      check("addi_alusel", 64'(CtrlWord[22:18]), 64'(ALU_ADD));
      check("addi_rw", 64'(CtrlWord[15]), 64'd1);
      check("addi_rin", 64'(CtrlWord[14:10]), 64'd1);
      check("addi_ra", 64'(CtrlWord[9:5]), 64'd2);
      check("addi_pcsel", 64'(CtrlWord[28:27]), 64'd1);
      check("addi_k", K, 64'd5);
      tick();

      fetch({11'h7C2, 9'h1F8, 2'b00, 5'd5, 5'd4});
      drive_check(1'b0);
      check("ldur_ex_pcsel", 64'(CtrlWord[28:27]), 64'd0);
      check("ldur_ex_rw", 64'(CtrlWord[15]), 64'd0);
      check("ldur_k", K, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      drive_check(1'b0);
      check("ldur_mem_ds", 64'(CtrlWord[25:24]), 64'd3);
      check("ldur_mem_rw", 64'(CtrlWord[15]), 64'd1);
      check("ldur_mem_rin", 64'(CtrlWord[14:10]), 64'd4);
      check("ldur_mem_pcsel", 64'(CtrlWord[28:27]), 64'd1);
      tick();
      check("ldur_back", 64'(StateOut), 64'd0);

      Flags = 4'b0100;
      fetch({8'h54, 19'd3, 1'b0, 4'h0});
      drive_check(1'b0);
      check("beq_t_pcsel", 64'(CtrlWord[28:27]), 64'd3);
      check("beq_t_k", K, 64'd12);
      tick();
      Flags = 4'b0000;
      fetch({8'h54, 19'd3, 1'b0, 4'h0});
      drive_check(1'b0);
      check("beq_nt_pcsel", 64'(CtrlWord[28:27]), 64'd1);
      tick();

      Status = 4'b0000;
      fetch({8'hB4, 19'h7FFFF, 5'd3});
      drive_check(1'b0);
      check("cbz_nt_pcsel", 64'(CtrlWord[28:27]), 64'd1);
      tick();
      Status = 4'b0100;
      fetch({8'hB4, 19'h7FFFF, 5'd3});
      drive_check(1'b0);
      check("cbz_t_pcsel", 64'(CtrlWord[28:27]), 64'd3);
      check("cbz_t_k", K, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();

      fetch({11'h458, 5'd3, 6'd0, 5'd2, 5'd1});
      for (int i = 0; i < 3; i++) begin
         drive_check(1'b1);
         check("stall_cw", 64'(CtrlWord), 64'd0);
         check("stall_state", 64'(StateOut), 64'd1);
         tick();
      end
      drive_check(1'b0);
      check("add_rw", 64'(CtrlWord[15]), 64'd1);
      check("add_rin", 64'(CtrlWord[14:10]), 64'd1);
      check("add_rb", 64'(CtrlWord[4:0]), 64'd3);
      tick();

      fetch(32'h0);
      drive_check(1'b0);
      check("ill_cw", 64'(CtrlWord), 64'd0);
      tick();
      drive_check(1'b1);
      check("halt_flag", 64'(Halted), 64'd1);
      check("halt_cw", 64'(CtrlWord), 64'd0);
      tick();
      Rst = 1'b1;
      step(1'b0);
      Rst = 1'b0;
      check("rst_halted", 64'(Halted), 64'd0);
      check("rst_state", 64'(StateOut), 64'd0);

      for (int i = 0; i < 4000; i++) begin
         Instruction = gen(mn_e'($urandom_range(0, 16)));
         Flags  = 4'($urandom());
         Status = 4'($urandom());
         Rst = ($urandom_range(0, 99) < 2) ||
               (m_st == 3 && $urandom_range(0, 3) == 0);
         step($urandom_range(0, 4) == 0);
      end
      Rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
